hazard_stall_unit: RTL and testbench

Pipeline control block that works alongside the forwarding unit. It resolves the hazards that forwarding cannot cover:
- load-use stalls
- taken-branch flushes
- data-memory wait freezes, with a watchdog timeout
It drives the PC and pipeline-register write enables and bubble/flush controls, and keeps saturating performance counters.

---
 rtl/hazard_stall_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, memory-wait
// freezes with a sticky watchdog, plus saturating performance counters.
module hazard_stall_unit #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IfIdRegRs,
    input  logic [4:0]       IfIdRegRt,
    input  logic             IfIdUsesRs,
    input  logic             IfIdUsesRt,
    input  logic             IdExMemRead,
    input  logic [4:0]       IdExRegRt,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    output logic             PcWrite,
    output logic             IfIdWrite,
    output logic             IfIdFlush,
    output logic             IdExBubble,
    output logic             PipeFreeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] LoadUseCount,
    output logic [1:0]       DbgState
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic [CNT_W-1:0]  lu_q, lu_d;
    logic              load_use;
    logic              sel_flush;
    logic              sel_lu;

    assign load_use = IdExMemRead && (IdExRegRt != 5'd0) &&
                      ((IfIdUsesRs && (IdExRegRt == IfIdRegRs)) ||
                       (IfIdUsesRt && (IdExRegRt == IfIdRegRt)));

    // Priority chain: freeze (timeout or busy) > branch flush > load-use > run.
    always_comb begin
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IfIdFlush  = 1'b0;
        IdExBubble = 1'b0;
        PipeFreeze = 1'b0;
        sel_flush  = 1'b0;
        sel_lu     = 1'b0;
        if (rst) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IfIdFlush  = 1'b1;
            IdExBubble = 1'b1;
        end else if ((state_q == ST_TIMEOUT) || MemBusy) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            PipeFreeze = 1'b1;
        end else if (BranchTaken) begin
            IfIdFlush  = 1'b1;
            IdExBubble = 1'b1;
            sel_flush  = 1'b1;
        end else if (load_use) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
            sel_lu     = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (MemBusy) begin
                    state_d = (MAX_WAIT == 1) ? ST_TIMEOUT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!MemBusy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WC_W'(MAX_WAIT - 1)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
        if (state_d == ST_TIMEOUT) begin
            timeout_d = 1'b1;
        end
        if (!MemBusy) begin
            wait_cnt_d = '0;
        end else if (state_q != ST_TIMEOUT) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        lu_d    = lu_q;
        if (!PcWrite && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
        if (sel_flush && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
        if (sel_lu && !(&lu_q)) lu_d = lu_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
            lu_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            lu_q       <= lu_d;
        end
    end

    assign MemTimeout   = timeout_q;
    assign StallCycles  = stall_q;
    assign FlushCount   = flush_q;
    assign LoadUseCount = lu_q;
    assign DbgState     = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model; a CNT_W=2 twin exercises saturation.
module tb_hazard_stall_unit;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;
    localparam int SAT_W    = 2;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] IfIdRegRs, IfIdRegRt, IdExRegRt;
    logic IfIdUsesRs, IfIdUsesRt, IdExMemRead, BranchTaken, MemBusy;

    logic PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze, MemTimeout;
    logic [CNT_W-1:0] StallCycles, FlushCount, LoadUseCount;
    logic [1:0] DbgState;

    logic s_PcWrite, s_IfIdWrite, s_IfIdFlush, s_IdExBubble, s_PipeFreeze, s_MemTimeout;
    logic [SAT_W-1:0] s_StallCycles, s_FlushCount, s_LoadUseCount;
    logic [1:0] s_DbgState;

    logic [4:0] ctrl;
    assign ctrl = {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze};

    int checks = 0;
    int errors = 0;

    // Model: timed-out flag, current busy run length, unbounded event totals
    bit m_timeout;
    int m_run, m_stall, m_flush, m_lu;

    hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt),
        .IfIdUsesRs(IfIdUsesRs), .IfIdUsesRt(IfIdUsesRt),
        .IdExMemRead(IdExMemRead), .IdExRegRt(IdExRegRt),
        .BranchTaken(BranchTaken), .MemBusy(MemBusy),
        .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
        .IdExBubble(IdExBubble), .PipeFreeze(PipeFreeze), .MemTimeout(MemTimeout),
        .StallCycles(StallCycles), .FlushCount(FlushCount),
        .LoadUseCount(LoadUseCount), .DbgState(DbgState)
    );

    hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt),
        .IfIdUsesRs(IfIdUsesRs), .IfIdUsesRt(IfIdUsesRt),
        .IdExMemRead(IdExMemRead), .IdExRegRt(IdExRegRt),
        .BranchTaken(BranchTaken), .MemBusy(MemBusy),
        .PcWrite(s_PcWrite), .IfIdWrite(s_IfIdWrite), .IfIdFlush(s_IfIdFlush),
        .IdExBubble(s_IdExBubble), .PipeFreeze(s_PipeFreeze), .MemTimeout(s_MemTimeout),
        .StallCycles(s_StallCycles), .FlushCount(s_FlushCount),
        .LoadUseCount(s_LoadUseCount), .DbgState(s_DbgState)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // 1 = frozen, 3 = branch flush, 4 = load-use bubble, 5 = run
    function automatic int model_case();
        bit lu;
        lu = IdExMemRead && (IdExRegRt != 0) &&
             ((IfIdUsesRs && IdExRegRt == IfIdRegRs) || (IfIdUsesRt && IdExRegRt == IfIdRegRt));
        if (m_timeout || MemBusy) return 1;
        if (BranchTaken) return 3;
        if (lu) return 4;
        return 5;
    endfunction

    function automatic logic [4:0] model_ctrl();
        case (model_case())
            1:       return 5'b00001;
            3:       return 5'b11110;
            4:       return 5'b00010;
            default: return 5'b11000;
        endcase
    endfunction

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- drivers ----------------
    task automatic clr_inputs();
        IfIdRegRs = 5'd0; IfIdRegRt = 5'd0; IdExRegRt = 5'd0;
        IfIdUsesRs = 1'b0; IfIdUsesRt = 1'b0; IdExMemRead = 1'b0;
        BranchTaken = 1'b0; MemBusy = 1'b0;
    endtask

    task automatic model_clear();
        m_timeout = 1'b0; m_run = 0; m_stall = 0; m_flush = 0; m_lu = 0;
    endtask

    // Clock edge with the model advanced on the same inputs; returns at posedge+1.
    task automatic tick();
        int c;
        c = model_case();
        @(posedge clk);
        if (c == 1 || c == 4) m_stall++;
        if (c == 3) m_flush++;
        if (c == 4) m_lu++;
        if (MemBusy) begin
            if (!m_timeout) begin
                m_run++;
                if (m_run >= MAX_WAIT) m_timeout = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        #1;
    endtask

    // Called at posedge+1; holds rst across one full edge, releases at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr_inputs();
        rst = 1'b1;
        #3;
        checks++; if (ctrl !== 5'b00110) begin errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl, 5'b00110); end
        checks++; if ({StallCycles, FlushCount, LoadUseCount} !== '0) begin errors++; $display("FAIL reset_counters got %h/%h/%h exp 0", StallCycles, FlushCount, LoadUseCount); end
        checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", MemTimeout); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (ctrl !== 5'b11000) begin errors++; $display("FAIL idle_ctrl got %b exp %b", ctrl, 5'b11000); end
        tick();
        checks++; if (StallCycles !== 16'd0) begin errors++; $display("FAIL idle_stall got %0d exp 0", StallCycles); end
    endtask

    task automatic test_load_use_rs();
        do_reset();
        clr_inputs();
        IdExMemRead = 1'b1; IdExRegRt = 5'd5; IfIdRegRs = 5'd5; IfIdUsesRs = 1'b1;
        @(negedge clk);
        checks++; if (ctrl !== 5'b00010) begin errors++; $display("FAIL lu_rs_ctrl got %b exp %b", ctrl, 5'b00010); end
        tick();
        clr_inputs();
        checks++; if (LoadUseCount !== 16'd1) begin errors++; $display("FAIL lu_rs_count got %0d exp 1", LoadUseCount); end
        checks++; if (StallCycles !== 16'd1) begin errors++; $display("FAIL lu_rs_stall got %0d exp 1", StallCycles); end
        @(negedge clk);
        checks++; if (ctrl !== 5'b11000) begin errors++; $display("FAIL lu_rs_after got %b exp %b", ctrl, 5'b11000); end
        tick();
    endtask

    task automatic test_false_hazard();
        do_reset();
        clr_inputs();
        IdExMemRead = 1'b1; IdExRegRt = 5'd0; IfIdRegRs = 5'd0; IfIdUsesRs = 1'b1;
        @(negedge clk);
        checks++; if (PcWrite !== 1'b1) begin errors++; $display("FAIL fh_r0_pcwrite got %b exp 1", PcWrite); end
        tick();
        checks++; if (LoadUseCount !== 16'd0) begin errors++; $display("FAIL fh_r0_count got %0d exp 0", LoadUseCount); end
        IdExRegRt = 5'd7; IfIdRegRt = 5'd7; IfIdUsesRt = 1'b0; IfIdRegRs = 5'd3; IfIdUsesRs = 1'b1;
        @(negedge clk);
        checks++; if (PcWrite !== 1'b1) begin errors++; $display("FAIL fh_rt_pcwrite got %b exp 1", PcWrite); end
        tick();
        checks++; if (LoadUseCount !== 16'd0) begin errors++; $display("FAIL fh_rt_count got %0d exp 0", LoadUseCount); end
        checks++; if (StallCycles !== 16'd0) begin errors++; $display("FAIL fh_rt_stall got %0d exp 0", StallCycles); end
        clr_inputs();
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        clr_inputs();
        IdExMemRead = 1'b1; IdExRegRt = 5'd9; IfIdRegRt = 5'd9; IfIdUsesRt = 1'b1; BranchTaken = 1'b1;
        @(negedge clk);
        checks++; if (ctrl !== 5'b11110) begin errors++; $display("FAIL br_lu_ctrl got %b exp %b", ctrl, 5'b11110); end
        tick();
        clr_inputs();
        checks++; if (FlushCount !== 16'd1) begin errors++; $display("FAIL br_lu_flush got %0d exp 1", FlushCount); end
        checks++; if (LoadUseCount !== 16'd0) begin errors++; $display("FAIL br_lu_lu got %0d exp 0", LoadUseCount); end
    endtask

    task automatic test_freeze_branch();
        do_reset();
        clr_inputs();
        BranchTaken = 1'b1; MemBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL frz_ctrl[%0d] got %b exp %b", i, ctrl, 5'b00001); end
            tick();
        end
        MemBusy = 1'b0;
        @(negedge clk);
        checks++; if (ctrl !== 5'b11110) begin errors++; $display("FAIL frz_release got %b exp %b", ctrl, 5'b11110); end
        tick();
        clr_inputs();
        checks++; if (StallCycles !== 16'd3) begin errors++; $display("FAIL frz_stall got %0d exp 3", StallCycles); end
        checks++; if (FlushCount !== 16'd1) begin errors++; $display("FAIL frz_flush got %0d exp 1", FlushCount); end
        checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL frz_timeout got %b exp 0", MemTimeout); end
    endtask

    task automatic test_watchdog();
        do_reset();
        clr_inputs();
        MemBusy = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL wd_early[%0d] got %b exp 0", i, MemTimeout); end
            tick();
        end
        checks++; if (MemTimeout !== 1'b1) begin errors++; $display("FAIL wd_set got %b exp 1", MemTimeout); end
        MemBusy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (ctrl !== 5'b00001 || MemTimeout !== 1'b1) begin errors++; $display("FAIL wd_hold[%0d] got %b/%b exp 00001/1", i, ctrl, MemTimeout); end
            tick();
        end
        checks++; if (StallCycles !== 16'(m_stall)) begin errors++; $display("FAIL wd_stall got %0d exp %0d", StallCycles, m_stall); end
        do_reset();
        checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp 0", MemTimeout); end
    endtask

    task automatic test_saturation();
        do_reset();
        clr_inputs();
        IdExMemRead = 1'b1; IdExRegRt = 5'd12; IfIdRegRs = 5'd12; IfIdUsesRs = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (s_LoadUseCount !== 2'd3) begin errors++; $display("FAIL sat_lu got %0d exp 3", s_LoadUseCount); end
        checks++; if (LoadUseCount !== 16'd5) begin errors++; $display("FAIL wide_lu got %0d exp 5", LoadUseCount); end
        checks++; if (s_StallCycles !== 2'd3) begin errors++; $display("FAIL sat_stall got %0d exp 3", s_StallCycles); end
        clr_inputs();
        MemBusy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #2;
        checks++; if ({StallCycles, LoadUseCount, s_StallCycles, s_LoadUseCount} !== '0) begin errors++; $display("FAIL rst_frz_counters got %h %h %h %h exp 0", StallCycles, LoadUseCount, s_StallCycles, s_LoadUseCount); end
        checks++; if (ctrl !== 5'b00110) begin errors++; $display("FAIL rst_frz_ctrl got %b exp %b", ctrl, 5'b00110); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        clr_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            IfIdRegRs   = 5'($urandom_range(0, 3));
            IfIdRegRt   = 5'($urandom_range(0, 3));
            IdExRegRt   = 5'($urandom_range(0, 3));
            IfIdUsesRs  = 1'($urandom_range(0, 1));
            IfIdUsesRt  = 1'($urandom_range(0, 1));
            IdExMemRead = 1'($urandom_range(0, 1));
            BranchTaken = ($urandom_range(0, 4) == 0);
            MemBusy     = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++; if (ctrl !== model_ctrl()) begin errors++; $display("FAIL rnd_ctrl[%0d] got %b exp %b", n, ctrl, model_ctrl()); end
            checks++; if (MemTimeout !== m_timeout) begin errors++; $display("FAIL rnd_timeout[%0d] got %b exp %b", n, MemTimeout, m_timeout); end
            tick();
            checks++; if ({StallCycles, FlushCount, LoadUseCount} !== {16'(sat(m_stall, CNT_W)), 16'(sat(m_flush, CNT_W)), 16'(sat(m_lu, CNT_W))}) begin
                errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", n, StallCycles, FlushCount, LoadUseCount, m_stall, m_flush, m_lu);
            end
            checks++; if ({s_StallCycles, s_FlushCount, s_LoadUseCount} !== {2'(sat(m_stall, SAT_W)), 2'(sat(m_flush, SAT_W)), 2'(sat(m_lu, SAT_W))}) begin
                errors++; $display("FAIL rnd_sat[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", n, s_StallCycles, s_FlushCount, s_LoadUseCount, sat(m_stall, SAT_W), sat(m_flush, SAT_W), sat(m_lu, SAT_W));
            end
        end
        clr_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_clear();
        test_reset();
        test_load_use_rs();
        test_false_hazard();
        test_branch_vs_load_use();
        test_freeze_branch();
        test_watchdog();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
